// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared constants for the audio CODEC blocks: the clock generator, the DAC
// serializer and the ADC deserializer.
//   DATA_WIDTH   bits per channel word
//   REF_CLK      reference clock frequency in Hz
//   SAMPLE_RATE  audio frame rate in Hz
//   CH_LEFT / CH_RIGHT  LRCK level that selects each channel
//   rx_state_t   ADC receive pairing state
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int REF_CLK     = 18432000;
    localparam int SAMPLE_RATE = 48000;

    localparam logic CH_LEFT  = 1'b1;
    localparam logic CH_RIGHT = 1'b0;

    // WAIT_LEFT: no complete left word is held.
    // LEFT_DONE: a complete left word waits for its right partner.
    typedef enum logic {
        WAIT_LEFT = 1'b0,
        LEFT_DONE = 1'b1
    } rx_state_t;

endpackage

// File: rtl/audio_sync_edge.sv
// ---------------------------------------------------------------------------
// audio_sync_edge
// N-stage synchronizer for one asynchronous input, with one extra history
// flop for edge detection.
//   iCLK_18_4  reference clock
//   iRST_N     asynchronous active-low reset
//   din        asynchronous input
//   level      synchronized level (STAGES clocks of delay)
//   rise       synchronized level went 0 -> 1
//   fall       synchronized level went 1 -> 0
//   any_edge   synchronized level changed
// ---------------------------------------------------------------------------
module audio_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic iCLK_18_4,
    input  logic iRST_N,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic any_edge
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level    = sync_q[STAGES-1];
    assign rise     = level & ~hist_q;
    assign fall     = ~level & hist_q;
    assign any_edge = level ^ hist_q;

endmodule

// File: rtl/audio_adc_deserializer.sv
// ---------------------------------------------------------------------------
// audio_adc_deserializer
// Receives the left-justified serial ADC stream (BCK/LRCK/ADCDAT) and
// presents one stereo pair per LRCK frame through a valid/ready handshake.
//   iCLK_18_4    18.432 MHz reference clock (only clock)
//   iRST_N       asynchronous active-low reset
//   iAUD_BCK     bit clock, sampled on its rising edge
//   iAUD_LRCK    frame clock, high = left, low = right
//   iAUD_ADCDAT  serial data, MSB first
//   oLEFT/oRIGHT presented sample pair
//   oVALID       pair presented
//   iREADY       consumer ready
//   oOVERRUN     sticky: a complete pair was dropped (output occupied)
//   iOVR_CLR     synchronous clear of oOVERRUN
//   oDBG_STATE   pairing state for observation
//
// Handshake: a pair transfers on any clock edge where oVALID and iREADY are
// both high. Once oVALID rises, oLEFT/oRIGHT hold steady until that transfer;
// oVALID never drops without a transfer except by reset.
// ---------------------------------------------------------------------------
module audio_adc_deserializer #(
    parameter int DATA_WIDTH  = audio_pkg::DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST_N,
    input  logic                  iAUD_BCK,
    input  logic                  iAUD_LRCK,
    input  logic                  iAUD_ADCDAT,
    output logic [DATA_WIDTH-1:0] oLEFT,
    output logic [DATA_WIDTH-1:0] oRIGHT,
    output logic                  oVALID,
    input  logic                  iREADY,
    output logic                  oOVERRUN,
    input  logic                  iOVR_CLR,
    output audio_pkg::rx_state_t  oDBG_STATE
);

    import audio_pkg::*;

    localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    // Synchronized inputs; all three see the same delay so alignment holds.
    logic bck_s, bck_rise;
    logic lr_s, lr_edge;
    logic dat_s;
    logic bck_fall_unused, bck_edge_unused;
    logic lr_rise_unused, lr_fall_unused;
    logic dat_rise_unused, dat_fall_unused, dat_edge_unused;

    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bck (
        .iCLK_18_4 (iCLK_18_4),
        .iRST_N    (iRST_N),
        .din       (iAUD_BCK),
        .level     (bck_s),
        .rise      (bck_rise),
        .fall      (bck_fall_unused),
        .any_edge  (bck_edge_unused)
    );

    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrck (
        .iCLK_18_4 (iCLK_18_4),
        .iRST_N    (iRST_N),
        .din       (iAUD_LRCK),
        .level     (lr_s),
        .rise      (lr_rise_unused),
        .fall      (lr_fall_unused),
        .any_edge  (lr_edge)
    );

    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dat (
        .iCLK_18_4 (iCLK_18_4),
        .iRST_N    (iRST_N),
        .din       (iAUD_ADCDAT),
        .level     (dat_s),
        .rise      (dat_rise_unused),
        .fall      (dat_fall_unused),
        .any_edge  (dat_edge_unused)
    );

    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] left_hold_q;
    logic                  chan_q;
    rx_state_t             state_q, state_d;

    logic [DATA_WIDTH-1:0] word;
    logic                  word_done, left_done, right_done;
    logic                  torn_left, pair_stb, accept;

    always_comb begin
        word       = {shift_q[DATA_WIDTH-2:0], dat_s};
        // An LRCK edge in the same cycle wins; that BCK rise is dropped.
        word_done  = bck_rise && !lr_edge && (cnt_q == CNT_LAST);
        left_done  = word_done && (chan_q == CH_LEFT);
        right_done = word_done && (chan_q == CH_RIGHT);
        torn_left  = lr_edge && (cnt_q < CNT_FULL) && (chan_q == CH_LEFT);
        pair_stb   = right_done && (state_q == LEFT_DONE);
        accept     = oVALID && iREADY;
    end

    // Pairing state: LEFT_DONE is the "left word held" flag.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) state_q <= WAIT_LEFT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LEFT: if (left_done)               state_d = LEFT_DONE;
            LEFT_DONE: if (right_done || torn_left) state_d = WAIT_LEFT;
            default:                                state_d = WAIT_LEFT;
        endcase
    end

    assign oDBG_STATE = state_q;

    // Framing and shifting. Rises beyond DATA_WIDTH in a half are ignored.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q       <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            chan_q      <= 1'b0;
        end else if (lr_edge) begin
            cnt_q   <= '0;
            shift_q <= '0;
            chan_q  <= lr_s;
        end else if (bck_rise && (cnt_q < CNT_FULL)) begin
            shift_q <= word;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (left_done) left_hold_q <= word;
        end
    end

    // Single-entry output register. A new pair may load in the same cycle
    // the old one is accepted; otherwise the newcomer is dropped.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            oLEFT  <= '0;
            oRIGHT <= '0;
            oVALID <= 1'b0;
        end else if (pair_stb && (!oVALID || iREADY)) begin
            oLEFT  <= left_hold_q;
            oRIGHT <= word;
            oVALID <= 1'b1;
        end else if (accept) begin
            oVALID <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N)                             oOVERRUN <= 1'b0;
        else if (pair_stb && oVALID && !iREADY)  oOVERRUN <= 1'b1;
        else if (iOVR_CLR)                       oOVERRUN <= 1'b0;
    end

endmodule

// File: tb/tb_audio_adc_deserializer.sv
module tb_audio_adc_deserializer;

    import audio_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bck, lrck, adcdat;
    logic [15:0] o_left, o_right;
    logic        o_valid, o_overrun;
    logic        ready, ovr_clr;
    rx_state_t   dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int valid_hi_cnt = 0;

    logic [31:0] got_q[$];
    int          got_cyc[$];
    logic [31:0] exp_q[$];

    audio_adc_deserializer #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
        .iCLK_18_4   (clk),
        .iRST_N      (rst_n),
        .iAUD_BCK    (bck),
        .iAUD_LRCK   (lrck),
        .iAUD_ADCDAT (adcdat),
        .oLEFT       (o_left),
        .oRIGHT      (o_right),
        .oVALID      (o_valid),
        .iREADY      (ready),
        .oOVERRUN    (o_overrun),
        .iOVR_CLR    (ovr_clr),
        .oDBG_STATE  (dbg_state)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe at the falling edge: values here are what the next rising
    // edge acts on, so valid & ready here means a transfer at that edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid) valid_hi_cnt = valid_hi_cnt + 1;
            if (o_valid && ready) begin
                got_q.push_back({o_left, o_right});
                got_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 2 ns after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Codec BFM: per bit, falling BCK with new LRCK/data, 6 clocks low,
    // rising BCK, 6 clocks high (12 clocks per BCK, 384 per frame).
    task automatic send_bits(input logic lr, input logic [15:0] w, input int msb,
                             input int n, input bit rdy_on_done, output int last_rise);
        last_rise = 0;
        for (int k = 0; k < n; k++) begin
            bck    = 1'b0;
            lrck   = lr;
            adcdat = w[msb-k];
            tick(6);
            bck       = 1'b1;
            last_rise = cyc;
            if (rdy_on_done && (k == n - 1)) begin
                // Completion edge is 3 edges after this drive.
                tick(2);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
                tick(3);
            end else begin
                tick(6);
            end
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int lbits,
                              input bit rdy_on_done, output int last_rise);
        int dummy;
        send_bits(1'b1, l, 15, lbits, 1'b0, dummy);
        send_bits(1'b0, r, 15, 16, rdy_on_done, last_rise);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        tick(3);
        total++; if (o_valid !== 1'b0)     begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        total++; if (o_left !== 16'h0)     begin bad++; $display("FAIL reset_left: got %h want 0000", o_left); end
        total++; if (o_right !== 16'h0)    begin bad++; $display("FAIL reset_right: got %h want 0000", o_right); end
        total++; if (o_overrun !== 1'b0)   begin bad++; $display("FAIL reset_overrun: got %b want 0", o_overrun); end
        total++; if (dbg_state !== WAIT_LEFT) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_basic;
        int base, vbase, lr;
        int rise[3];
        ready = 1'b1;
        base  = got_q.size();
        vbase = valid_hi_cnt;
        // Partial frame: 8 left bits then a full right half.
        send_bits(1'b1, 16'hA5C3, 15, 8, 1'b0, lr);
        send_bits(1'b0, 16'h5A3C, 15, 16, 1'b0, lr);
        total++; if (got_q.size() !== base) begin bad++; $display("FAIL basic_partial_discard: got %0d pairs want 0", got_q.size() - base); end
        for (int i = 0; i < 3; i++) send_frame(16'hA5C3, 16'h5A3C, 16, 1'b0, rise[i]);
        total++;
        if (got_q.size() !== base + 3) begin
            bad++; $display("FAIL basic_count: got %0d pairs want 3", got_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (got_q[base+i] !== 32'hA5C3_5A3C) begin bad++; $display("FAIL basic_data%0d: got %h want a5c35a3c", i, got_q[base+i]); end
                total++; if (got_cyc[base+i] - rise[i] !== 3) begin bad++; $display("FAIL basic_latency%0d: got %0d want 3", i, got_cyc[base+i] - rise[i]); end
            end
            total++; if (got_cyc[base+1] - got_cyc[base] !== 384) begin bad++; $display("FAIL basic_period: got %0d want 384", got_cyc[base+1] - got_cyc[base]); end
        end
        total++; if (valid_hi_cnt - vbase !== 3) begin bad++; $display("FAIL basic_pulse_width: got %0d valid cycles want 3", valid_hi_cnt - vbase); end
    endtask

    task automatic test_overrun;
        int base, lr;
        ready = 1'b0;
        base  = got_q.size();
        send_frame(16'h1234, 16'h8001, 16, 1'b0, lr);
        total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL ovr_early: got %b want 0", o_overrun); end
        send_frame(16'hFFFF, 16'h0000, 16, 1'b0, lr);
        total++; if (o_valid !== 1'b1)    begin bad++; $display("FAIL ovr_held_valid: got %b want 1", o_valid); end
        total++; if ({o_left, o_right} !== 32'h1234_8001) begin bad++; $display("FAIL ovr_held_data: got %h want 12348001", {o_left, o_right}); end
        total++; if (o_overrun !== 1'b1)  begin bad++; $display("FAIL ovr_flag: got %b want 1", o_overrun); end
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        total++; if (o_valid !== 1'b0)    begin bad++; $display("FAIL ovr_accept_valid: got %b want 0", o_valid); end
        total++; if (o_overrun !== 1'b1)  begin bad++; $display("FAIL ovr_sticky: got %b want 1", o_overrun); end
        total++;
        if (got_q.size() !== base + 1) begin
            bad++; $display("FAIL ovr_accept_count: got %0d pairs want 1", got_q.size() - base);
        end else if (got_q[base] !== 32'h1234_8001) begin
            bad++; $display("FAIL ovr_accept_data: got %h want 12348001", got_q[base]);
        end
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        total++; if (o_overrun !== 1'b0)  begin bad++; $display("FAIL ovr_clear: got %b want 0", o_overrun); end
    endtask

    task automatic test_accept_load;
        int base, lr;
        ready = 1'b0;
        base  = got_q.size();
        send_frame(16'hAAAA, 16'h5555, 16, 1'b0, lr);
        send_frame(16'h1357, 16'h2468, 16, 1'b1, lr);
        total++; if (o_valid !== 1'b1)   begin bad++; $display("FAIL al_valid: got %b want 1", o_valid); end
        total++; if ({o_left, o_right} !== 32'h1357_2468) begin bad++; $display("FAIL al_data: got %h want 13572468", {o_left, o_right}); end
        total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL al_overrun: got %b want 0", o_overrun); end
        total++;
        if (got_q.size() !== base + 1) begin
            bad++; $display("FAIL al_old_count: got %0d pairs want 1", got_q.size() - base);
        end else if (got_q[base] !== 32'hAAAA_5555) begin
            bad++; $display("FAIL al_old_data: got %h want aaaa5555", got_q[base]);
        end
        ready = 1'b1;
        tick(2);
        ready = 1'b0;
        total++; if (got_q.size() !== base + 2 || got_q[got_q.size()-1] !== 32'h1357_2468) begin
            bad++; $display("FAIL al_drain: got %0d pairs last %h want 2 / 13572468", got_q.size() - base, got_q[got_q.size()-1]);
        end
    endtask

    task automatic test_torn_left;
        int base, lr;
        ready = 1'b1;
        base  = got_q.size();
        send_bits(1'b1, 16'h0F0F, 15, 9, 1'b0, lr);
        send_bits(1'b0, 16'h1111, 15, 16, 1'b0, lr);
        total++; if (got_q.size() !== base) begin bad++; $display("FAIL torn_discard: got %0d pairs want 0", got_q.size() - base); end
        send_frame(16'hC0DE, 16'hBEEF, 16, 1'b0, lr);
        total++;
        if (got_q.size() !== base + 1) begin
            bad++; $display("FAIL torn_next_count: got %0d pairs want 1", got_q.size() - base);
        end else if (got_q[base] !== 32'hC0DE_BEEF) begin
            bad++; $display("FAIL torn_next_data: got %h want c0debeef", got_q[base]);
        end
    endtask

    task automatic test_reset_mid;
        int base, lr;
        ready = 1'b0;
        send_frame(16'h2222, 16'h3333, 16, 1'b0, lr);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL rm_pre_valid: got %b want 1", o_valid); end
        send_bits(1'b1, 16'h4444, 15, 16, 1'b0, lr);
        send_bits(1'b0, 16'h5555, 15, 8, 1'b0, lr);
        rst_n = 1'b0;
        #1;
        total++; if (o_valid !== 1'b0)   begin bad++; $display("FAIL rm_valid: got %b want 0", o_valid); end
        total++; if (o_left !== 16'h0)   begin bad++; $display("FAIL rm_left: got %h want 0000", o_left); end
        total++; if (o_right !== 16'h0)  begin bad++; $display("FAIL rm_right: got %h want 0000", o_right); end
        total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL rm_overrun: got %b want 0", o_overrun); end
        tick(2);
        rst_n = 1'b1;
        ready = 1'b1;
        base  = got_q.size();
        send_bits(1'b0, 16'h5555, 7, 8, 1'b0, lr);
        total++; if (got_q.size() !== base) begin bad++; $display("FAIL rm_discard: got %0d pairs want 0", got_q.size() - base); end
        send_frame(16'h6666, 16'h7777, 16, 1'b0, lr);
        total++;
        if (got_q.size() !== base + 1) begin
            bad++; $display("FAIL rm_next_count: got %0d pairs want 1", got_q.size() - base);
        end else begin
            if (got_q[base] !== 32'h6666_7777) begin bad++; $display("FAIL rm_next_data: got %h want 66667777", got_q[base]); end
            total++; if (got_cyc[base] - lr !== 3) begin bad++; $display("FAIL rm_latency: got %0d want 3", got_cyc[base] - lr); end
        end
    endtask

    task automatic test_extremes;
        int base, lr;
        ready = 1'b1;
        base  = got_q.size();
        exp_q.delete();
        exp_q.push_back(32'h8000_0001);
        exp_q.push_back(32'h7FFF_FFFE);
        send_frame(16'h8000, 16'h0001, 16, 1'b0, lr);
        send_frame(16'h7FFF, 16'hFFFE, 16, 1'b0, lr);
        total++;
        if (got_q.size() !== base + exp_q.size()) begin
            bad++; $display("FAIL ext_count: got %0d pairs want %0d", got_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++; if (got_q[base+i] !== exp_q[i]) begin bad++; $display("FAIL ext_data%0d: got %h want %h", i, got_q[base+i], exp_q[i]); end
            end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst_n   = 1'b0;
        bck     = 1'b0;
        lrck    = 1'b0;
        adcdat  = 1'b0;
        ready   = 1'b0;
        ovr_clr = 1'b0;
        test_reset();
        test_basic();
        test_overrun();
        test_accept_load();
        test_torn_left();
        test_reset_mid();
        test_extremes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_adc_deserializer.md
# audio_adc_deserializer

Receives the left-justified serial ADC stream from the audio CODEC and delivers one parallel stereo sample pair (16-bit left, 16-bit right) per LRCK frame through a valid/ready handshake. It is the receive-side counterpart of the audio clock generator. It consumes the generated BCK/LRCK and the codec's ADCDAT pin, all in the 18.432 MHz reference domain, and hands samples to the CPU-side audio FIFO/MMIO logic.

## Interface
- DATA_WIDTH, 16: bits per channel word; exactly DATA_WIDTH BCK rising edges per LRCK half-period.
- SYNC_STAGES, 2: synchronizer depth on the three serial inputs, minimum 2.
- iCLK_18_4  in  1  18.432 MHz reference clock; the only clock.
- iRST_N  in  1  asynchronous, active-low reset.
- iAUD_BCK  in  1  bit clock. Codec shifts data on the falling edge; this block samples on the rising edge.
- iAUD_LRCK  in  1  frame clock; high = left channel, low = right channel.
- iAUD_ADCDAT  in  1  serial ADC data, MSB first.
- oLEFT  out  DATA_WIDTH  left sample of the presented pair.
- oRIGHT  out  DATA_WIDTH  right sample of the presented pair.
- oVALID  out  1  pair presented.
- iREADY  in  1  consumer accepts the pair when oVALID and iREADY are both high on a clock edge.
- oOVERRUN  out  1  sticky: a complete pair was dropped because the output was still occupied.
- iOVR_CLR  in  1  synchronous clear of oOVERRUN.

## Operation
- **Synchronization.** BCK, LRCK and ADCDAT each pass through SYNC_STAGES flops, plus one extra BCK/LRCK history flop for edge detection. All three inputs share the same delay, so their alignment is preserved.
- **Edge detection.**
  - bck_rise: synchronized BCK is 1 and the history flop is 0.
  - lr_edge: synchronized LRCK differs from its history flop.
- **Framing.**
  - lr_edge clears the bit counter and the shift register and latches the current channel (the LRCK level).
  - An lr_edge with counter < DATA_WIDTH discards the partial word. If the discarded word is left, left_ok is cleared.
- **Shifting.**
  - On each bck_rise with counter < DATA_WIDTH: shift_reg <= {shift_reg, adcdat}, counter increments.
  - Bit rises beyond DATA_WIDTH within one half are ignored.
  - lr_edge and bck_rise in the same cycle: the lr_edge clear takes priority and that rise is dropped. With the clock generator's timing this cannot occur, because LRCK changes on a BCK falling edge.
- **Word complete** (bck_rise with counter == DATA_WIDTH-1):
  - Left channel: the full word goes to left_hold; left_ok <= 1.
  - Right channel with left_ok = 1: the pair {left_hold, new word} is offered to the output stage; left_ok <= 0.
  - Right channel with left_ok = 0: the word is discarded. This covers the first frame after reset or after a torn left half.
- **Output stage** is a single-entry register:
  - Empty, or being accepted this cycle (oVALID & iREADY): load the pair, oVALID <= 1.
  - Otherwise: the new pair is dropped, the old pair is kept unchanged, oOVERRUN <= 1.
  - Accept with no new pair arriving: oVALID <= 0.
- **Overrun clear.** iOVR_CLR clears oOVERRUN. An overrun event in the same cycle wins, so the flag stays 1.
- **State machine** (derived from left_ok and the latched channel):
  - WAIT_LEFT → LEFT_DONE on a completed left word.
  - LEFT_DONE → WAIT_LEFT on a completed right word (pair emitted) or on a torn left half.

## Timing
- **Reset values.** While iRST_N is low:
  - oLEFT = 0, oRIGHT = 0, oVALID = 0, oOVERRUN = 0.
  - Synchronizers, history flops, counter, shift register, left_hold, left_ok and the latched channel are all cleared.
  - Deassertion mid-frame leads to a discarded first pair through the left_ok rule.
- **Latency.** Let E0 be the first iCLK_18_4 edge that samples the final right-channel BCK high. oVALID and the data are registered at edge E0+SYNC_STAGES and appear immediately after it (E0+2 by default).
- **Throughput.** One pair per LRCK period: 384 clocks at 48 kHz, with 12 clocks per BCK period.
- **Minimum input period.** BCK high and low phases must each be at least 2 reference clocks.
- **Outputs.** oLEFT/oRIGHT are stable whenever oVALID is high and change only on load.

## Structure
- Shared package audio_pkg holds:
  - DATA_WIDTH default 16, REF_CLK 18432000, SAMPLE_RATE 48000;
  - the channel encoding constants CH_LEFT = 1'b1 and CH_RIGHT = 1'b0, also used by the clock generator and the DAC serializer.
- One sub-module: audio_sync_edge, an N-stage synchronizer that outputs the level, rising, falling and any-edge pulses. It is instantiated for BCK and LRCK; ADCDAT uses its level output only.
- Total RTL of 150–250 lines.

## Test plan
- **Basic frame.** Stimulus: drive from the real clock generator; codec BFM sends left 0xA5C3, right 0x5A3C, iREADY = 1. Required response:
  - the first partial frame after reset is discarded;
  - then oLEFT = 0xA5C3 and oRIGHT = 0x5A3C with a one-cycle oVALID pulse every 384 clocks, 2 clocks after the last right BCK rise.
- **Backpressure/overrun.** Stimulus: hold iREADY = 0 across two frames. Required response:
  - the first pair (0x1234/0x8001) is held;
  - the second pair (0xFFFF/0x0000) is dropped and oOVERRUN = 1;
  - after iREADY the held pair is accepted and oVALID = 0;
  - iOVR_CLR then returns oOVERRUN to 0.
- **Accept and load in the same cycle.** Stimulus: raise iREADY exactly on the completion cycle. Required response: the new pair loads, oVALID stays 1, oOVERRUN stays 0.
- **Torn left half.** Stimulus: toggle LRCK after 9 left bits. Required response: that frame's right word is discarded, no oVALID; the next full frame is delivered correctly.
- **Reset mid-frame.** Stimulus: pulse iRST_N low during the right half with oVALID = 1. Required response:
  - all outputs become 0 immediately;
  - the first complete pair after reset is delivered one full frame later.
- **Extremes.** Stimulus: data patterns 0x8000/0x0001 and 0x7FFF/0xFFFE. Required response: the patterns are reproduced bit-exactly (MSB/LSB ordering).
